// File: rtl/skip_borrow_subtractor_pkg.sv
// ---------------------------------------------------------------------------
// skip_sub_pkg
//   Shared definitions for the multi-cycle skip-borrow subtractor:
//     - state_t            : controller state encoding (IDLE, RUN, DONE)
//     - SKIP_SUB_W_DEFAULT : default operand/result width
//     - SKIP_SUB_BLK_DEFAULT : default slice width (bits per clock)
//     - idx_width()        : width of the slice index counter, never below 1
// ---------------------------------------------------------------------------
package skip_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SKIP_SUB_W_DEFAULT   = 16;
    localparam int SKIP_SUB_BLK_DEFAULT = 4;

    // A single-slice configuration still needs a 1-bit index register.
    function automatic int idx_width(input int nblk);
        return (nblk > 1) ? $clog2(nblk) : 1;
    endfunction

endpackage

// File: rtl/skip_borrow_subtractor_slice.sv
// ---------------------------------------------------------------------------
// skip_slice
//   Combinational BLOCK-bit slice of the subtract datapath. The caller feeds
//   the minuend slice and the already-inverted subtrahend slice, so the slice
//   is a plain adder with a carry-skip bypass.
//   Ports:
//     a_s   in  BLOCK  minuend slice
//     nb_s  in  BLOCK  inverted subtrahend slice
//     cin   in  1      carry into the slice
//     sum_s out BLOCK  difference slice
//     cout  out 1      carry out (bypassed from cin when every bit propagates)
//     skip  out 1      1 when the bypass path is taken
// ---------------------------------------------------------------------------
module skip_slice #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a_s,
    input  logic [BLOCK-1:0] nb_s,
    input  logic             cin,
    output logic [BLOCK-1:0] sum_s,
    output logic             cout,
    output logic             skip
);

    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] ripple_c;
    logic             ripple_cout;

    // Per-bit propagate/generate terms, XOR-based propagate.
    for (genvar gi = 0; gi < BLOCK; gi++) begin : g_pg
        assign p[gi] = a_s[gi] ^ nb_s[gi];
        assign g[gi] = a_s[gi] & nb_s[gi];
    end

    // Ripple chain built with a running variable so the carry vector has no
    // self-referencing continuous assignment.
    always_comb begin
        logic c;
        c = cin;
        ripple_c = '0;
        for (int i = 0; i < BLOCK; i++) begin
            ripple_c[i] = c;
            c = g[i] | (p[i] & c);
        end
        ripple_cout = c;
    end

    assign sum_s = p ^ ripple_c;
    assign skip  = &p;
    // When every bit propagates the slice output is cin itself; the bypass
    // cuts the chain without changing the logical result.
    assign cout  = skip ? cin : ripple_cout;

endmodule

// File: rtl/skip_borrow_subtractor.sv
// ---------------------------------------------------------------------------
// skip_borrow_subtractor
//   Multi-cycle subtractor, diff = a - b (mod 2^WIDTH), computed one BLOCK-bit
//   slice per clock as a + ~b + 1 through a carry-skip slice. Valid/ready on
//   both sides; one operation every NBLK+2 cycles, result valid NBLK cycles
//   after the accepting edge.
//   Optional feature macro: SKIP_SUB_OVF_EN adds the signed-overflow port ovf.
//   Ports:
//     clk         in   1      rising-edge clock
//     rst_n       in   1      asynchronous active-low reset
//     in_valid    in   1      operands valid
//     in_ready    out  1      operands accepted (IDLE only)
//     a           in   WIDTH  minuend
//     b           in   WIDTH  subtrahend
//     out_valid   out  1      result valid, held until out_ready
//     out_ready   in   1      consumer takes the result
//     diff        out  WIDTH  a - b
//     borrow_out  out  1      1 when a < b unsigned
//     ovf         out  1      signed overflow (SKIP_SUB_OVF_EN only)
// ---------------------------------------------------------------------------
module skip_borrow_subtractor
    import skip_sub_pkg::*;
#(
    parameter int WIDTH = SKIP_SUB_W_DEFAULT,
    parameter int BLOCK = SKIP_SUB_BLK_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SKIP_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NBLK = WIDTH / BLOCK;
    localparam int IDXW = idx_width(NBLK);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBLK - 1);

    if (BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_bad_cfg
        $error("skip_borrow_subtractor: WIDTH must be a positive multiple of BLOCK");
    end

    state_t            state_reg;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  nb_reg;
    logic              carry_reg;
    logic [IDXW-1:0]   blk_idx_reg;
    logic [WIDTH-1:0]  diff_reg;
    logic              borrow_reg;
    logic              in_ready_reg;
    logic              out_valid_reg;

    logic [BLOCK-1:0]  slice_a;
    logic [BLOCK-1:0]  slice_nb;
    logic [BLOCK-1:0]  slice_sum;
    logic              slice_cout;
    logic              slice_skip;
    logic              unused_skip;

    assign slice_a  = a_reg[int'(blk_idx_reg)*BLOCK +: BLOCK];
    assign slice_nb = nb_reg[int'(blk_idx_reg)*BLOCK +: BLOCK];

    skip_slice #(
        .BLOCK (BLOCK)
    ) u_slice (
        .a_s   (slice_a),
        .nb_s  (slice_nb),
        .cin   (carry_reg),
        .sum_s (slice_sum),
        .cout  (slice_cout),
        .skip  (slice_skip)
    );

    // The bypass decision is consumed inside the slice; it is kept visible
    // here for debug probing only.
    assign unused_skip = slice_skip;

`ifdef SKIP_SUB_OVF_EN
    logic ovf_reg;
    logic ovf_next;

    // Evaluated on the top slice only. b's sign is the inverse of nb's top
    // bit, so "signs differ" is a_top == nb_top.
    assign ovf_next = (slice_a[BLOCK-1] == slice_nb[BLOCK-1])
                   && (slice_sum[BLOCK-1] != slice_a[BLOCK-1]);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            nb_reg        <= '0;
            carry_reg     <= 1'b0;
            blk_idx_reg   <= '0;
            diff_reg      <= '0;
            borrow_reg    <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
`ifdef SKIP_SUB_OVF_EN
            ovf_reg       <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    // in_ready_reg is 1 throughout IDLE.
                    if (in_valid) begin
                        a_reg        <= a;
                        nb_reg       <= ~b;
                        carry_reg    <= 1'b1;   // +1 of the two's-complement negate
                        blk_idx_reg  <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= RUN;
                    end
                end

                RUN: begin
                    diff_reg[int'(blk_idx_reg)*BLOCK +: BLOCK] <= slice_sum;
                    carry_reg <= slice_cout;
                    if (blk_idx_reg == LAST_IDX) begin
                        borrow_reg    <= ~slice_cout;
`ifdef SKIP_SUB_OVF_EN
                        ovf_reg       <= ovf_next;
`endif
                        blk_idx_reg   <= '0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        blk_idx_reg <= blk_idx_reg + IDXW'(1);
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end

                default: begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    blk_idx_reg   <= '0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_reg;
    assign out_valid  = out_valid_reg;
    assign diff       = diff_reg;
    assign borrow_out = borrow_reg;
`ifdef SKIP_SUB_OVF_EN
    assign ovf        = ovf_reg;
`endif

endmodule
